steer_quad_encoder: RTL and testbench



---
 rtl/steer_pkg.sv | 20 ++
 rtl/steer_sync.sv | 25 ++
 rtl/steer_quad_encoder.sv | 112 +++++++++++
 tb/tb_steer_quad_encoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/steer_pkg.sv
// steer_pkg: shared types and helpers for the quadrature steering encoder.
//   steer_state_t : FSM states (IDLE, RUN_R, RUN_L)
//   GRAY          : phase -> {A,B} quadrature code, indexed by 2-bit phase
//   quad_next     : advances the phase one step right (dir=1) or left (dir=0)
package steer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_R = 2'd1,
        RUN_L = 2'd2
    } steer_state_t;

    // GRAY[0]=00, GRAY[1]=01, GRAY[2]=11, GRAY[3]=10
    localparam logic [3:0][1:0] GRAY = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] quad_next(input logic [1:0] phase, input logic dir);
        return dir ? (phase + 2'd1) : (phase - 2'd1);
    endfunction

endpackage

// File: rtl/steer_sync.sv
// steer_sync: generic 2-flop level synchronizer.
//   CLK     : destination clock
//   Reset_n : async active-low reset, both flops clear to 0
//   d       : asynchronous input level
//   q       : synchronized level, two CLK edges after d is first sampled
module steer_sync (
    input  logic CLK,
    input  logic Reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/steer_quad_encoder.sv
// steer_quad_encoder: turns left/right joystick levels into a continuous
// Gray-code quadrature step stream for the game core's SteerA/SteerB inputs.
//   CLK     : core clock (rising edge)
//   Reset_n : async active-low reset; deassertion expected synchronous to CLK
//   left    : steer-left request (asynchronous, synchronized internally)
//   right   : steer-right request (asynchronous, synchronized internally)
//   steer   : {A,B} quadrature pair, holds its value while idle
//   moving  : high while stepping in either direction
//   dir     : direction of the most recent step (1 = right)
// Build option: define STEER_ACCEL_EN to enable the hold-to-accelerate ramp
// (ACCEL_HOLD steps per speed level, up to MAX_LEVEL halvings of CLKDIV).
module steer_quad_encoder
    import steer_pkg::*;
#(
    parameter int CLKDIV     = 22500,
    parameter int ACCEL_HOLD = 8,
    parameter int MAX_LEVEL  = 2
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       left,
    input  logic       right,
    output logic [1:0] steer,
    output logic       moving,
    output logic       dir
);

    localparam int DW = $clog2(CLKDIV);
    localparam int LW = (MAX_LEVEL > 0) ? $clog2(MAX_LEVEL + 1) : 1;

    logic          sl, sr;
    steer_state_t  state, ns;
    logic [DW-1:0] div;
    logic [DW-1:0] per_m1;
    logic [LW-1:0] level;
    logic [1:0]    phase, nphase;
    logic          entry, wrap, step, step_right;

    steer_sync u_sync_l (.CLK(CLK), .Reset_n(Reset_n), .d(left),  .q(sl));
    steer_sync u_sync_r (.CLK(CLK), .Reset_n(Reset_n), .d(right), .q(sr));

    always_comb begin
        ns = IDLE;
        if (sr && !sl)      ns = RUN_R;
        else if (sl && !sr) ns = RUN_L;
    end

    // Step period for the current speed level, never below one cycle.
    always_comb begin
        int p;
        p = CLKDIV >> level;
        if (p < 1) p = 1;
        per_m1 = DW'(p - 1);
    end

    // Entry covers IDLE->RUN_x and direct reversal; both fire a step at once
    // and restart the divider so the next step lands exactly P cycles later.
    assign entry      = (ns != state);
    assign wrap       = (state != IDLE) && !entry && (div == per_m1);
    assign step       = (entry && (ns != IDLE)) || wrap;
    assign step_right = (ns == RUN_R);
    assign nphase     = quad_next(phase, step_right);
    assign moving     = (state != IDLE);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            div   <= '0;
            phase <= 2'd0;
            steer <= 2'b00;
            dir   <= 1'b1;
        end else begin
            state <= ns;
            if (entry || wrap || (state == IDLE)) div <= '0;
            else                                  div <= div + 1'b1;
            if (step) begin
                phase <= nphase;
                steer <= GRAY[nphase];
                dir   <= step_right;
            end
        end
    end

`ifdef STEER_ACCEL_EN
    localparam int HW = (ACCEL_HOLD > 1) ? $clog2(ACCEL_HOLD) : 1;

    logic [HW-1:0] hold;

    // Only divider wraps advance the ramp; the entry step restarts it, so the
    // first ACCEL_HOLD periods after any entry run at base rate. The level
    // changes on a wrap, so the new period applies to the very next count.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            hold  <= '0;
            level <= '0;
        end else if (entry) begin
            hold  <= '0;
            level <= '0;
        end else if (wrap) begin
            if (hold == HW'(ACCEL_HOLD - 1)) begin
                hold <= '0;
                if (level != LW'(MAX_LEVEL)) level <= level + 1'b1;
            end else begin
                hold <= hold + 1'b1;
            end
        end
    end
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_steer_quad_encoder.sv
module tb_steer_quad_encoder;

    localparam int CLKDIV     = 8;
    localparam int ACCEL_HOLD = 2;
    localparam int MAX_LEVEL  = 2;

    logic       CLK = 1'b0;
    logic       Reset_n = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic [1:0] steer;
    logic       moving;
    logic       dir;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    steer_quad_encoder #(
        .CLKDIV(CLKDIV), .ACCEL_HOLD(ACCEL_HOLD), .MAX_LEVEL(MAX_LEVEL)
    ) dut (
        .CLK(CLK), .Reset_n(Reset_n), .left(left), .right(right),
        .steer(steer), .moving(moving), .dir(dir)
    );

    // ---------------- reference model ----------------
    // Requests act two edges after they are sampled; a step is a +/-1 move
    // of an integer position, emitted on entry and then whenever the time
    // since the last step reaches the period for the number of timed steps.
    int         gray_tab[4] = '{0, 1, 3, 2};
    int         m_mode;       // 0 idle, 1 right, 2 left
    int         m_pos;
    logic       m_dir;
    int         m_last;
    int         m_k;
    int         cyc = 0;
    logic [1:0] hist0, hist1;

    function automatic int period(input int k);
        int p;
`ifdef STEER_ACCEL_EN
        int lvl;
        lvl = k / ACCEL_HOLD;
        if (lvl > MAX_LEVEL) lvl = MAX_LEVEL;
        p = CLKDIV >> lvl;
        if (p < 1) p = 1;
`else
        p = CLKDIV + 0 * k;
`endif
        return p;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_dir = 1'b1; m_last = 0; m_k = 0;
        hist0 = 2'b00; hist1 = 2'b00;
    endtask

    task automatic do_step();
        m_pos = (m_mode == 1) ? ((m_pos + 1) % 4) : ((m_pos + 3) % 4);
        m_dir = (m_mode == 1);
    endtask

    task automatic chk(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model at the rising edge, compare on the falling edge.
    task automatic tick();
        logic [1:0] req_in;
        int req;
        @(posedge CLK);
        cyc++;
        if (!Reset_n) begin
            model_reset();
        end else begin
            req_in = hist1;
            hist1  = hist0;
            hist0  = {left, right};
            req = (req_in == 2'b01) ? 1 : (req_in == 2'b10) ? 2 : 0;
            if (req != m_mode) begin
                m_mode = req;
                if (req != 0) begin
                    do_step(); m_last = cyc; m_k = 0;
                end
            end else if (m_mode != 0 && (cyc - m_last) == period(m_k)) begin
                do_step(); m_last = cyc; m_k++;
            end
        end
        @(negedge CLK);
        chk("model_steer",  steer,  gray_tab[m_pos]);
        chk("model_moving", moving, (m_mode != 0) ? 1 : 0);
        chk("model_dir",    dir,    m_dir);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       l;
        logic       r;
        int         n;
        logic [1:0] st;
        logic       mv;
        logic       dr;
    } vec_t;

    vec_t vt[14];

    task automatic setv(input int i, input logic l, input logic r, input int n,
                        input logic [1:0] st, input logic mv, input logic dr);
        vt[i].l = l; vt[i].r = r; vt[i].n = n; vt[i].st = st; vt[i].mv = mv; vt[i].dr = dr;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         bad;
        int         ts[$];
        int         exp_int[7];
        logic [1:0] prev;
        int         changes;
        int         hold_cnt;

        model_reset();

        // Right from idle: 01 after 2 edges, 11 eight cycles later, then left
        // reversal walks back 01, 00, 10; both pressed -> idle; right alone
        // re-enters with an immediate step; release freezes the output.
        setv(0,  0, 1, 3,  2'b01, 1, 1);
        setv(1,  0, 1, 8,  2'b11, 1, 1);
        setv(2,  1, 0, 1,  2'b11, 1, 1);
        setv(3,  1, 0, 2,  2'b01, 1, 0);
        setv(4,  1, 0, 8,  2'b00, 1, 0);
        setv(5,  1, 0, 8,  2'b10, 1, 0);
        setv(6,  1, 1, 2,  2'b10, 1, 0);
        setv(7,  1, 1, 1,  2'b10, 0, 0);
        setv(8,  1, 1, 20, 2'b10, 0, 0);
        setv(9,  0, 1, 2,  2'b10, 0, 0);
        setv(10, 0, 1, 1,  2'b00, 1, 1);
        setv(11, 0, 0, 2,  2'b00, 1, 1);
        setv(12, 0, 0, 1,  2'b00, 0, 1);
        setv(13, 0, 0, 10, 2'b00, 0, 1);

`ifdef STEER_ACCEL_EN
        exp_int = '{8, 8, 4, 4, 2, 2, 2};
`else
        exp_int = '{8, 8, 8, 8, 8, 8, 8};
`endif

        // Reset values while held in reset
        tick(); tick();
        chk("rst_steer", steer, 0);
        chk("rst_moving", moving, 0);
        chk("rst_dir", dir, 1);
        Reset_n = 1'b1;

        // Reset asserted mid-run clears outputs immediately
        right = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("pre_rst_moving", moving, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_steer", steer, 0);
        chk("async_rst_moving", moving, 0);
        chk("async_rst_dir", dir, 1);
        model_reset();
        right = 1'b0;
        tick();
        Reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (steer !== 2'b00 || moving !== 1'b0) bad++;
        end
        chk("post_rst_idle_cycles_bad", bad, 0);

        // Table-driven directed sequence
        for (int i = 0; i < 14; i++) begin
            left = vt[i].l; right = vt[i].r;
            for (int c = 0; c < vt[i].n; c++) tick();
            chk($sformatf("vec%0d_steer", i),  steer,  vt[i].st);
            chk($sformatf("vec%0d_moving", i), moving, vt[i].mv);
            chk($sformatf("vec%0d_dir", i),    dir,    vt[i].dr);
        end

        // Hold right: step latency and intervals (ramp when enabled)
        left = 1'b0; right = 1'b1;
        prev = steer;
        ts.delete();
        for (int c = 0; c < 200 && ts.size() < 8; c++) begin
            tick();
            if (steer !== prev) begin ts.push_back(c); prev = steer; end
        end
        chk("accel_nsteps", ts.size(), 8);
        if (ts.size() > 0) chk("accel_latency", ts[0], 2);
        for (int i = 1; i < ts.size(); i++)
            chk($sformatf("accel_int%0d", i), ts[i] - ts[i-1], exp_int[i-1]);

        // Release and re-press restores base period
        right = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("release_moving", moving, 0);
        right = 1'b1;
        prev = steer;
        ts.delete();
        for (int c = 0; c < 100 && ts.size() < 3; c++) begin
            tick();
            if (steer !== prev) begin ts.push_back(c); prev = steer; end
        end
        chk("repress_nsteps", ts.size(), 3);
        for (int i = 1; i < ts.size(); i++)
            chk($sformatf("repress_int%0d", i), ts[i] - ts[i-1], 8);
        right = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // One-cycle glitch: never more than one step
        prev = steer; changes = 0;
        right = 1'b1;
        tick();
        right = 1'b0;
        if (steer !== prev) begin changes++; prev = steer; end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (steer !== prev) begin changes++; prev = steer; end
        end
        chk("glitch_1cyc_at_most_one", (changes <= 1) ? 1 : 0, 1);
        chk("glitch_1cyc_idle", moving, 0);

        // Glitch entirely between edges: never sampled, no step
        prev = steer; changes = 0;
        #1 right = 1'b1;
        #2 right = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (steer !== prev) begin changes++; prev = steer; end
        end
        chk("glitch_short_none", changes, 0);

        // Randomized run against the model
        hold_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_cnt == 0) begin
                case ($urandom_range(0, 5))
                    0:       begin left = 1'b0; right = 1'b0; end
                    1, 2:    begin left = 1'b0; right = 1'b1; end
                    3, 4:    begin left = 1'b1; right = 1'b0; end
                    default: begin left = 1'b1; right = 1'b1; end
                endcase
                hold_cnt = $urandom_range(1, 40);
            end
            hold_cnt--;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
